// File: rtl/cla_carry_stage_if.sv
// Valid/ready bundle between the operand source, the CLA carry stage and the
// downstream summation stage.
interface cla_carry_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, p, c, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, p, c, cout
  );
endinterface

// File: rtl/cla_carry_stage.sv
// Two-stage carry-lookahead front end: stage 1 registers bit and group P/G,
// stage 2 resolves group and bit carries and presents p, c and cout.
module cla_carry_stage #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic              clk,
  input logic              rst_n,
  cla_carry_stage_if.slave bus
);
  localparam int NGRP = WIDTH / GROUP;

  logic             s1_valid;
  logic [WIDTH-1:0] p1;
  logic [WIDTH-1:0] g1;
  logic             cin1;
  logic [NGRP-1:0]  gp1;
  logic [NGRP-1:0]  gg1;

  logic             out_valid_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] c_q;
  logic             cout_q;

  logic [WIDTH-1:0] bp;
  logic [WIDTH-1:0] bg;
  logic [NGRP-1:0]  gp_d;
  logic [NGRP-1:0]  gg_d;
  logic [NGRP:0]    gc;
  logic [WIDTH-1:0] c_d;
  logic             adv1;
  logic             adv2;

  // Ready looks only at downstream state, never at in_valid.
  assign adv2         = s1_valid & (~out_valid_q | bus.out_ready);
  assign bus.in_ready = ~s1_valid | adv2;
  assign adv1         = bus.in_valid & bus.in_ready;

  assign bp = bus.a ^ bus.b;
  assign bg = bus.a & bus.b;

  // Group propagate/generate: gg = g3 | p3g2 | p3p2g1 | p3p2p1g0 for GROUP=4.
  always_comb begin
    logic term;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gp_d = '0;
    gg_d = '0;
    term = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      gp_d[k] = &bp[k*GROUP +: GROUP];
      for (int j = 0; j < GROUP; j++) begin
        term = bg[k*GROUP + j];
        for (int m = j + 1; m < GROUP; m++) term = term & bp[k*GROUP + m];
        gg_d[k] = gg_d[k] | term;
      end
    end
  end

  // Group carries ripple between groups; bit carries inside a group are flat
  // sum-of-products from the group carry-in, so no chain exceeds GROUP.
  always_comb begin
    logic term;
    logic acc;
    gc    = '0;
    c_d   = '0;
    term  = 1'b0;
    acc   = 1'b0;
    gc[0] = cin1;
    for (int k = 0; k < NGRP; k++) begin
      gc[k+1] = gg1[k] | (gp1[k] & gc[k]);
      for (int i = 0; i < GROUP; i++) begin
        term = gc[k];
        for (int j = 0; j < i; j++) term = term & p1[k*GROUP + j];
        acc = term;
        for (int j = 0; j < i; j++) begin
          term = g1[k*GROUP + j];
          for (int m = j + 1; m < i; m++) term = term & p1[k*GROUP + m];
          acc = acc | term;
        end
        c_d[k*GROUP + i] = acc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      p1       <= '0;
      g1       <= '0;
      cin1     <= 1'b0;
      gp1      <= '0;
      gg1      <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= 1'b1;
        p1       <= bp;
        g1       <= bg;
        cin1     <= bus.cin;
        gp1      <= gp_d;
        gg1      <= gg_d;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      c_q         <= '0;
      cout_q      <= 1'b0;
    end else begin
      if (adv2) begin
        out_valid_q <= 1'b1;
        p_q         <= p1;
        c_q         <= c_d;
        cout_q      <= gc[NGRP];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.c         = c_q;
  assign bus.cout      = cout_q;
endmodule
